// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_gen
// Purpose  : Turns each accepted trigger from the trigger selector into one
//            burst of N fixed-width pulses for the IRE output stage. While a
//            burst is in flight, further triggers are rejected and flagged.
//            A sticky finished flag stops all activity once the latched
//            trigger count reaches the programmed burst limit.
// Ports    : sys_clk, rst_n (async, active-low), en, trig, trig_count,
//            pulse_width, pulse_gap, pulses_per_burst, burst_limit
//            -> pulse_p, pulse_n, busy, burst_done, missed_trig, finished
// Options  : PULSE_BIPHASIC_EN - when defined each pulse becomes
//            POS(w) -> DEAD(DEAD_CYC) -> NEG(w); otherwise pulse_n is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_train_gen #(
    parameter int CNT_W    = 16,
    parameter int CNT_IN_W = 10,
    parameter int DEAD_CYC = 4
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                trig,
    input  logic [CNT_IN_W-1:0] trig_count,
    input  logic [CNT_W-1:0]    pulse_width,
    input  logic [CNT_W-1:0]    pulse_gap,
    input  logic [7:0]          pulses_per_burst,
    input  logic [CNT_IN_W-1:0] burst_limit,
    output logic                pulse_p,
    output logic                pulse_n,
    output logic                busy,
    output logic                burst_done,
    output logic                missed_trig,
    output logic                finished
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_POS  = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
`ifdef PULSE_BIPHASIC_EN
    localparam logic [2:0] S_DEAD = 3'd3;
    localparam logic [2:0] S_NEG  = 3'd4;
`endif

    // A dead time of zero would collapse the DEAD phase; keep at least one cycle.
    localparam logic [CNT_W-1:0] C_DEAD_EFF = (DEAD_CYC < 1) ? CNT_W'(1) : CNT_W'(DEAD_CYC);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    logic [2:0]          r_state;
    logic [CNT_W-1:0]    r_tcnt;     // cycle number within the current phase, starts at 1
    logic [7:0]          r_pcnt;     // completed pulses in this burst
    logic [CNT_W-1:0]    r_width;
    logic [CNT_W-1:0]    r_gap;
    logic [7:0]          r_n;
    logic [CNT_IN_W-1:0] r_count;

    logic [CNT_W-1:0]    w_width_eff;
    logic [CNT_W-1:0]    w_gap_eff;
    logic                w_last;
    logic                w_limit_hit;
    logic                w_accept_hit;

    assign w_width_eff  = (pulse_width == '0) ? C_ONE : pulse_width;
    assign w_gap_eff    = (pulse_gap == '0) ? C_ONE : pulse_gap;
    // Nine-bit compare so the pulse counter never wraps against N.
    assign w_last       = ({1'b0, r_pcnt} + 9'd1) >= {1'b0, r_n};
    assign w_limit_hit  = (burst_limit != '0) && (r_count >= burst_limit);
    // N=0 finishes on the accept edge, before the latched count is visible.
    assign w_accept_hit = (burst_limit != '0) && (trig_count >= burst_limit);

`ifndef PULSE_BIPHASIC_EN
    assign pulse_n = 1'b0;
    logic unused_dead_cfg;
    assign unused_dead_cfg = ^C_DEAD_EFF;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tcnt      <= '0;
            r_pcnt      <= '0;
            r_width     <= '0;
            r_gap       <= '0;
            r_n         <= '0;
            r_count     <= '0;
            pulse_p     <= 1'b0;
            busy        <= 1'b0;
            burst_done  <= 1'b0;
            missed_trig <= 1'b0;
            finished    <= 1'b0;
`ifdef PULSE_BIPHASIC_EN
            pulse_n     <= 1'b0;
`endif
        end else begin
            burst_done  <= 1'b0;
            missed_trig <= 1'b0;
            if (!en) begin
                // Abort: drop everything without signalling burst_done.
                r_state  <= S_IDLE;
                r_tcnt   <= '0;
                r_pcnt   <= '0;
                pulse_p  <= 1'b0;
                busy     <= 1'b0;
                finished <= 1'b0;
`ifdef PULSE_BIPHASIC_EN
                pulse_n  <= 1'b0;
`endif
            end else begin
                if (trig && !finished && (r_state != S_IDLE)) begin
                    missed_trig <= 1'b1;
                end
                case (r_state)
                    S_IDLE: begin
                        busy <= 1'b0;
                        if (trig && !finished) begin
                            r_width <= w_width_eff;
                            r_gap   <= w_gap_eff;
                            r_n     <= pulses_per_burst;
                            r_count <= trig_count;
                            r_pcnt  <= '0;
                            r_tcnt  <= C_ONE;
                            busy    <= 1'b1;
                            if (pulses_per_burst == 8'd0) begin
                                burst_done <= 1'b1;
                                if (w_accept_hit) begin
                                    finished <= 1'b1;
                                end
                            end else begin
                                r_state <= S_POS;
                                pulse_p <= 1'b1;
                            end
                        end
                    end
                    S_POS: begin
                        if (r_tcnt >= r_width) begin
                            pulse_p <= 1'b0;
                            r_tcnt  <= C_ONE;
`ifdef PULSE_BIPHASIC_EN
                            r_state <= S_DEAD;
`else
                            if (w_last) begin
                                r_state    <= S_IDLE;
                                busy       <= 1'b0;
                                burst_done <= 1'b1;
                                if (w_limit_hit) begin
                                    finished <= 1'b1;
                                end
                            end else begin
                                r_state <= S_GAP;
                                r_pcnt  <= r_pcnt + 8'd1;
                            end
`endif
                        end else begin
                            r_tcnt <= r_tcnt + C_ONE;
                        end
                    end
                    S_GAP: begin
                        if (r_tcnt >= r_gap) begin
                            r_state <= S_POS;
                            pulse_p <= 1'b1;
                            r_tcnt  <= C_ONE;
                        end else begin
                            r_tcnt <= r_tcnt + C_ONE;
                        end
                    end
`ifdef PULSE_BIPHASIC_EN
                    S_DEAD: begin
                        if (r_tcnt >= C_DEAD_EFF) begin
                            r_state <= S_NEG;
                            pulse_n <= 1'b1;
                            r_tcnt  <= C_ONE;
                        end else begin
                            r_tcnt <= r_tcnt + C_ONE;
                        end
                    end
                    S_NEG: begin
                        if (r_tcnt >= r_width) begin
                            pulse_n <= 1'b0;
                            r_tcnt  <= C_ONE;
                            if (w_last) begin
                                r_state    <= S_IDLE;
                                busy       <= 1'b0;
                                burst_done <= 1'b1;
                                if (w_limit_hit) begin
                                    finished <= 1'b1;
                                end
                            end else begin
                                r_state <= S_GAP;
                                r_pcnt  <= r_pcnt + 8'd1;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + C_ONE;
                        end
                    end
`endif
                    default: begin
                        r_state <= S_IDLE;
                        pulse_p <= 1'b0;
                        busy    <= 1'b0;
`ifdef PULSE_BIPHASIC_EN
                        pulse_n <= 1'b0;
`endif
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
